rf_console: RTL and testbench
=============================

// Module: rf_console
// PURPOSE
//  Parametrised bench-top console for the RISC-V register file: owns a NUM_REGS x XLEN register file
//  (x0 hardwired to zero), an address register loaded from switches, and a debounced one-shot button FSM.
//  Feeds operands to an external ALU, takes the ALU result back, and pages any XLEN-wide read value onto
//  16 LEDs. Sits at board top level between the switches/buttons and the ALU under test.
// PARAMETERS
//  XLEN            32  data width; multiple of 16, >= 16
//  NUM_REGS        32  register count; power of 2, 2..32; AW = $clog2(NUM_REGS)
//  DEBOUNCE_CYCLES 4   consecutive stable synchronised cycles required to accept a press or release; >= 1
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       asynchronous, active-low reset
//  btnc       in   1       async button: write register
//  btnl       in   1       async button: load address register
//  btnd       in   1       async button: advance LED page
//  sw         in   16      sw[15]=write source select, sw[14:0]=immediate/addresses, sw[3:0]=ALU op
//  alu_result in   XLEN    result from external ALU
//  alu_op     out  4       sw[3:0], combinational pass-through
//  op_a       out  XLEN    read data, port A (addr field [AW-1:0])
//  op_b       out  XLEN    read data, port B (addr field [2AW-1:AW])
//  reg_write  out  1       one-cycle strobe: write committed this cycle
//  addr_load  out  1       one-cycle strobe: address register loaded this cycle
//  led        out  16      op_a[16*page +: 16]
// BEHAVIOUR
//  - Reset: address register, all registers, page counter, FSM (WAIT), debounce counter, strobes = 0;
//    led/op_a/op_b therefore read 0.
//  - Buttons pass a 2-flop synchroniser; all behaviour below uses the synchronised values.
//  - Address register (3*AW bits): on addr_load, <= sw[3*AW-1:0]; fields A=[AW-1:0], B=[2AW-1:AW],
//    W=[3AW-1:2AW]. Unused sw bits are ignored.
//  - Write data = sw[15] ? {sign-extend sw[14] to XLEN, sw[14:0]} : alu_result; sampled at the reg_write edge.
//  - Writes are synchronous on reg_write; a write to W=0 is discarded; x0 always reads 0.
//  - Reads are combinational; new data is visible on op_a/op_b the cycle after the write.
//  - FSM states:
//    WAIT:  btnc|btnl high -> ARM, counter cleared.
//    ARM:   counter increments while the same button set stays high. Any change -> WAIT.
//           counter==DEBOUNCE_CYCLES-1 -> FIRE.
//    FIRE:  exactly one cycle. btnc -> reg_write; else btnl -> addr_load. btnc wins when both are high;
//           no address load in that case. Then -> HOLD.
//    HOLD:  btnc=btnl=0 for DEBOUNCE_CYCLES consecutive cycles -> WAIT; any high restarts the count.
//  - Latency: press edge -> strobe = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. One strobe per press,
//    regardless of hold length.
//  - Page counter (log2(XLEN/16) bits): +1 on each synchronised rising edge of btnd, wraps to 0 after
//    XLEN/16-1. Fixed 0 when XLEN==16.
//  - Reset mid-operation: FSM returns to WAIT immediately, no strobe; a press still held after release
//    of reset must fully re-debounce.
// CONFIGURATION
//  RF_FORWARD_EN defined:
//    - When reg_write is high and A (or B) == W != 0, op_a (or op_b) returns the write data in that same
//      cycle, so alu_result reflects it combinationally.
//    - Combinational loop guard: forwarding applies only when sw[15]=1. With sw[15]=0 the path is not
//      forwarded.
//  RF_FORWARD_EN undefined: no forwarding; reads always return stored contents.
// TESTING  (XLEN=32, NUM_REGS=32, DEBOUNCE_CYCLES=4)
//  - Reset release, no buttons -> led=0, op_a=op_b=0, strobes 0 for 100 cycles.
//  - sw=0x0C41, press btnl 20 cycles -> single addr_load pulse 7 cycles after edge; A=1, B=2, W=3.
//  - Then sw=0xFFFE, press btnc -> single reg_write; x3=0xFFFFFFFE. Reload addresses so A=3:
//    led=0xFFFE; one btnd press -> led=0xFFFF; second btnd press -> 0xFFFE.
//  - Write with W=0, then read A=0 -> op_a=0.
//  - btnc bouncing 1-2-cycle pulses for 30 cycles -> no strobe. btnc and btnl in the same cycle ->
//    reg_write only.
//  - Assert reset_n=0 during ARM -> no strobe. RF_FORWARD_EN with A=W=5, sw[15]=1, sw[14:0]=0x0007
//    -> op_a=7 in the reg_write cycle.

Source files
------------

// File: rtl/rf_console.sv
// Bench-top register-file console: debounced buttons drive writes/address loads, LEDs page op_a.
// Optional RF_FORWARD_EN: same-cycle write-data forwarding onto op_a/op_b for immediate writes.
module rf_console #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            btnc,
  input  logic            btnl,
  input  logic            btnd,
  input  logic [15:0]     sw,
  input  logic [XLEN-1:0] alu_result,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            reg_write,
  output logic            addr_load,
  output logic [15:0]     led
);

  localparam int unsigned AW    = $clog2(NUM_REGS);
  localparam int unsigned PAGES = XLEN / 16;
  localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {S_WAIT, S_ARM, S_FIRE, S_HOLD} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [1:0]          armed;
  logic [2:0]          sync1, sync2;
  logic                bc, bl, bd, bd_q;
  logic [PW-1:0]       page;
  logic [3*AW-1:0]     addr_q;
  logic [AW-1:0]       a_addr, b_addr, w_addr;
  logic [XLEN-1:0]     wdata;
  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [PAGES-1:0][15:0] op_a_pages;

  assign alu_op = sw[3:0];
  assign bc     = sync2[0];
  assign bl     = sync2[1];
  assign bd     = sync2[2];
  assign a_addr = addr_q[AW-1:0];
  assign b_addr = addr_q[2*AW-1:AW];
  assign w_addr = addr_q[3*AW-1:2*AW];
  assign wdata  = sw[15] ? {{(XLEN-15){sw[14]}}, sw[14:0]} : alu_result;

  // Two-flop synchronisers for the asynchronous buttons
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btnd, btnl, btnc};
      sync2 <= sync1;
    end
  end

  // Debounce / one-shot FSM; strobes are registered on entry to FIRE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_WAIT;
      cnt       <= '0;
      armed     <= '0;
      reg_write <= 1'b0;
      addr_load <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      addr_load <= 1'b0;
      case (state)
        S_WAIT: begin
          if (bc | bl) begin
            state <= S_ARM;
            cnt   <= '0;
            armed <= {bl, bc};
          end
        end
        S_ARM: begin
          if ({bl, bc} != armed) begin
            state <= S_WAIT;
          end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            state     <= S_FIRE;
            reg_write <= bc;
            addr_load <= bl & ~bc;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIRE: begin
          state <= S_HOLD;
          cnt   <= '0;
        end
        S_HOLD: begin
          if (bc | bl) begin
            cnt <= '0;
          end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            state <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else if (addr_load) begin
      addr_q <= sw[3*AW-1:0];
    end
  end

  // Register file; entry 0 is never written and never read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_write && (w_addr != '0)) begin
      regs[w_addr] <= wdata;
    end
  end

  always_comb begin
    op_a = (a_addr == '0) ? '0 : regs[a_addr];
    op_b = (b_addr == '0) ? '0 : regs[b_addr];
`ifdef RF_FORWARD_EN
    // Only immediate data is forwarded so alu_result never loops back into op_a/op_b
    if (reg_write && sw[15] && (w_addr != '0)) begin
      if (a_addr == w_addr) op_a = wdata;
      if (b_addr == w_addr) op_b = wdata;
    end
`endif
  end

  // LED page counter advances on each synchronised rising edge of btnd
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bd_q <= 1'b0;
      page <= '0;
    end else begin
      bd_q <= bd;
      if (bd && !bd_q) begin
        if (page == PW'(PAGES - 1)) page <= '0;
        else                        page <= page + PW'(1);
      end
    end
  end

  assign op_a_pages = op_a;
  assign led        = op_a_pages[page];

endmodule

// File: tb/tb_rf_console.sv
// Randomized self-checking bench for rf_console against a transaction-level register-file model.
module tb_rf_console;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NR   = 32;
  localparam int unsigned DB   = 4;
  localparam int unsigned LAT  = 2 + DB + 1;

  logic        clk = 1'b0;
  logic        reset_n, btnc, btnl, btnd;
  logic [15:0] sw;
  logic [31:0] alu_result;
  logic [3:0]  alu_op;
  logic [31:0] op_a, op_b;
  logic        reg_write, addr_load;
  logic [15:0] led;

  rf_console #(.XLEN(XLEN), .NUM_REGS(NR), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .btnc(btnc), .btnl(btnl), .btnd(btnd), .sw(sw),
    .alu_result(alu_result), .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .reg_write(reg_write), .addr_load(addr_load), .led(led)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts pulses and remembers when the last one was seen
  int unsigned n_wr = 0, n_ld = 0, t_wr = 0, t_ld = 0, pc = 0;
  always @(negedge clk) begin
    if (reg_write === 1'b1) begin n_wr++; t_wr = cyc; end
    if (addr_load === 1'b1) begin n_ld++; t_ld = cyc; end
  end

  logic [31:0] m_rf [NR];
  int unsigned m_a, m_b, m_w, m_page;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int unsigned a);
    return (a == 0) ? 32'h0 : m_rf[a];
  endfunction

  function automatic logic [31:0] wval(input logic [15:0] s, input logic [31:0] alu);
    logic signed [14:0] imm;
    imm = s[14:0];
    return s[15] ? 32'(imm) : alu;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_rf[i] = '0;
    m_a = 0; m_b = 0; m_w = 0; m_page = 0;
  endtask

  task automatic press(input logic c, input logic l, input logic d, input int hold);
    @(negedge clk);
    pc = cyc;
    btnc = c; btnl = l; btnd = d;
    repeat (hold) @(negedge clk);
    btnc = 1'b0; btnl = 1'b0; btnd = 1'b0;
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic check_reads(input string tag);
    logic [31:0] va;
    va = rd(m_a);
    chk({tag, "_opa"}, op_a, va);
    chk({tag, "_opb"}, op_b, rd(m_b));
    chk({tag, "_led"}, {16'h0, led}, {16'h0, (m_page == 1) ? va[31:16] : va[15:0]});
  endtask

  task automatic load_addr(input int unsigned a, input int unsigned b, input int unsigned w);
    int unsigned l0, w0;
    l0 = n_ld; w0 = n_wr;
    sw = 16'((w << 10) | (b << 5) | a);
    press(1'b0, 1'b1, 1'b0, 12);
    chk("ld_cnt", n_ld - l0, 1);
    chk("ld_lat", t_ld - pc, LAT);
    chk("ld_nowr", n_wr - w0, 0);
    m_a = a; m_b = b; m_w = w;
    check_reads("ld");
  endtask

  task automatic write_sw(input logic [15:0] s, input logic [31:0] alu);
    int unsigned l0, w0;
    l0 = n_ld; w0 = n_wr;
    sw = s; alu_result = alu;
    press(1'b1, 1'b0, 1'b0, 12);
    chk("wr_cnt", n_wr - w0, 1);
    chk("wr_lat", t_wr - pc, LAT);
    chk("wr_nold", n_ld - l0, 0);
    if (m_w != 0) m_rf[m_w] = wval(s, alu);
    check_reads("wr");
  endtask

  task automatic page_step();
    press(1'b0, 1'b0, 1'b1, 6);
    m_page = (m_page + 1) % (XLEN / 16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0, l0, r, elapsed, wsel;
    logic [31:0] old5;
    reset_n = 1'b0; btnc = 1'b0; btnl = 1'b0; btnd = 1'b0;
    sw = '0; alu_result = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset: everything reads zero, no strobes
    repeat (100) begin
      @(negedge clk);
      chk("rst_led", {16'h0, led}, 32'h0);
      chk("rst_opa", op_a, 32'h0);
      chk("rst_opb", op_b, 32'h0);
      chk("rst_strobes", {30'h0, reg_write, addr_load}, 32'h0);
    end
    chk("alu_op", {28'h0, alu_op}, {28'h0, sw[3:0]});

    // Directed sequence
    load_addr(1, 2, 3);
    write_sw(16'hFFFE, 32'h0);
    load_addr(3, 2, 3);
    chk("x3_led0", {16'h0, led}, 32'h0000_FFFE);
    page_step();
    chk("x3_led1", {16'h0, led}, 32'h0000_FFFF);
    page_step();
    chk("x3_led2", {16'h0, led}, 32'h0000_FFFE);
    load_addr(0, 3, 0);
    write_sw(16'h8123, 32'h0);
    chk("x0_zero", op_a, 32'h0);

    // Random writes via immediate and ALU paths, read back through both ports
    for (int it = 0; it < 30; it++) begin
      wsel = $urandom_range(0, NR - 1);
      load_addr($urandom_range(0, NR - 1), $urandom_range(0, NR - 1), wsel);
      sw = 16'($urandom);
      chk("rnd_aluop", {28'h0, alu_op}, {28'h0, sw[3:0]});
      if ($urandom_range(0, 1) == 1) write_sw({1'b1, 15'($urandom)}, $urandom);
      else                           write_sw({1'b0, 15'($urandom)}, $urandom);
      load_addr(wsel, $urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
      if ($urandom_range(0, 3) == 0) begin
        page_step();
        check_reads("rnd_pg");
      end
    end

    // Bouncing btnc never holds long enough to fire
    w0 = n_wr; l0 = n_ld; elapsed = 0;
    while (elapsed < 30) begin
      int unsigned hi, lo;
      hi = $urandom_range(1, 2); lo = $urandom_range(1, 2);
      @(negedge clk); btnc = 1'b1;
      repeat (hi - 1) @(negedge clk);
      @(negedge clk); btnc = 1'b0;
      repeat (lo - 1) @(negedge clk);
      elapsed += hi + lo;
    end
    repeat (DB + 8) @(negedge clk);
    chk("bounce_wr", n_wr - w0, 0);
    chk("bounce_ld", n_ld - l0, 0);

    // Simultaneous buttons: write wins, no address load
    w0 = n_wr; l0 = n_ld;
    sw = 16'h8055;
    press(1'b1, 1'b1, 1'b0, 12);
    chk("both_wr", n_wr - w0, 1);
    chk("both_ld", n_ld - l0, 0);
    if (m_w != 0) m_rf[m_w] = wval(sw, alu_result);
    check_reads("both");

    // Same-cycle read of the register being written
    load_addr(5, 5, 5);
    old5 = rd(5);
    w0 = n_wr;
    sw = 16'h8007;
    @(negedge clk); pc = cyc; btnc = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("fwd_strobe", {31'h0, reg_write}, 32'h1);
`ifdef RF_FORWARD_EN
    chk("fwd_opa", op_a, 32'h7);
    chk("fwd_opb", op_b, 32'h7);
`else
    chk("nofwd_opa", op_a, old5);
    chk("nofwd_opb", op_b, old5);
`endif
    repeat (5) @(negedge clk);
    btnc = 1'b0;
    repeat (DB + 8) @(negedge clk);
    chk("fwd_cnt", n_wr - w0, 1);
    m_rf[5] = 32'h7;
    check_reads("fwd_after");

    // Reset while armed: no strobe, then a still-held press re-debounces from scratch
    sw = 16'((9 << 10) | (8 << 5) | 7);
    l0 = n_ld;
    @(negedge clk); btnl = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstarm_ld", n_ld - l0, 0);
    reset_n = 1'b1;
    r = cyc;
    model_reset();
    check_reads("rstarm");
    repeat (15) @(negedge clk);
    btnl = 1'b0;
    repeat (DB + 8) @(negedge clk);
    chk("rstarm_ld2", n_ld - l0, 1);
    chk("rstarm_lat", t_ld - r, LAT);
    m_a = 7; m_b = 8; m_w = 9;
    write_sw(16'h1234, 32'h0);
    load_addr(9, 7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
